// File: rtl/usb_slave_req_engine.sv
// Turns FIFO'd write requests and mux'd read requests into single-cycle UHCI register/memory accesses.
// Read toggles 3 edges after request; one write per 3 cycles; optional address checking under USB_SLAVE_ADDR_CHECK_EN.
module usb_slave_req_engine #(
   parameter int ADDR_W    = 32,
   parameter int Data_W    = 32,
   parameter int usb_mem_W = 6
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [1:0]           Read_en,
   input  logic [Data_W-1:0]    R_address_mux,
   input  logic                 empty,
   input  logic [ADDR_W-1:0]    fifo_addr,
   input  logic [Data_W-1:0]    fifo_data,
   output logic                 rd_en_fifo,
   output logic [usb_mem_W-1:0] mem_addr,
   output logic [Data_W-1:0]    mem_wdata,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [Data_W-1:0]    mem_rdata,
   output logic [7:0]           reg_addr,
   output logic [7:0]           reg_wdata,
   output logic                 reg_we,
   output logic                 reg_re,
   input  logic [7:0]           reg_rdata,
   output logic [Data_W-1:0]    r_data_mem,
   output logic [7:0]           r_data_reg,
   output logic                 data_mem_toggle,
   output logic                 data_reg_toggle,
`ifdef USB_SLAVE_ADDR_CHECK_EN
   output logic                 addr_err,
`endif
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR_POP, WR_ISSUE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_armed;
   logic              rd_start;
   logic              rd_illegal;
   logic              wr_illegal;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{rd_addr, fifo_addr};

`ifdef USB_SLAVE_ADDR_CHECK_EN
   function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
      return (|a[ADDR_W-1:11]) || (!a[10] && (|a[9:usb_mem_W+2]));
   endfunction
   assign rd_illegal = addr_illegal(rd_addr);
   assign wr_illegal = addr_illegal(fifo_addr);
`else
   assign rd_illegal = 1'b0;
   assign wr_illegal = 1'b0;
`endif

   assign rd_start = (state == IDLE) && (Read_en == 2'b01) && rd_armed;
   assign busy     = (state != IDLE);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state           <= IDLE;
         rd_addr         <= '0;
         rd_armed        <= 1'b1;
         r_data_mem      <= '0;
         r_data_reg      <= '0;
         data_mem_toggle <= 1'b0;
         data_reg_toggle <= 1'b0;
`ifdef USB_SLAVE_ADDR_CHECK_EN
         addr_err        <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (rd_start)
            rd_addr <= ADDR_W'(R_address_mux);
         // Re-arm wins over the clear so a read phase that already ended is not lost.
         if (Read_en != 2'b01)
            rd_armed <= 1'b1;
         else if (state == RD_CAPT)
            rd_armed <= 1'b0;
         if (state == RD_CAPT) begin
            if (rd_addr[10]) begin
               r_data_reg      <= rd_illegal ? 8'hFF : reg_rdata;
               data_reg_toggle <= ~data_reg_toggle;
            end else begin
               r_data_mem      <= rd_illegal ? '1 : mem_rdata;
               data_mem_toggle <= ~data_mem_toggle;
            end
         end
`ifdef USB_SLAVE_ADDR_CHECK_EN
         if ((state == RD_CAPT && rd_illegal) || (state == WR_ISSUE && wr_illegal))
            addr_err <= 1'b1;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      rd_en_fifo = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      reg_we     = 1'b0;
      reg_re     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      reg_addr   = '0;
      reg_wdata  = '0;
      case (state)
         IDLE: begin
            if (rd_start)
               state_nxt = RD_ISSUE;
            else if (Read_en == 2'b10 && !empty)
               state_nxt = WR_POP;
         end
         RD_ISSUE: begin
            if (!rd_illegal) begin
               if (rd_addr[10]) begin
                  reg_re   = 1'b1;
                  reg_addr = rd_addr[9:2];
               end else begin
                  mem_re   = 1'b1;
                  mem_addr = rd_addr[usb_mem_W+1:2];
               end
            end
            state_nxt = RD_CAPT;
         end
         RD_CAPT: state_nxt = IDLE;
         WR_POP: begin
            rd_en_fifo = 1'b1;
            state_nxt  = WR_ISSUE;
         end
         WR_ISSUE: begin
            // FIFO heads are valid now, one cycle after the pop.
            if (!wr_illegal) begin
               if (fifo_addr[10]) begin
                  reg_we    = 1'b1;
                  reg_addr  = fifo_addr[9:2];
                  reg_wdata = fifo_data[7:0];
               end else begin
                  mem_we    = 1'b1;
                  mem_addr  = fifo_addr[usb_mem_W+1:2];
                  mem_wdata = fifo_data;
               end
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
